// File: rtl/conv_acc_pkg.sv
// Shared definitions for the Wishbone 1-D convolution engine: register map,
// FSM state encoding, CTRL/STATUS bit positions and accumulator sizing.
package conv_acc_pkg;

  localparam logic [11:0] CTRL_OFF    = 12'h000;
  localparam logic [11:0] STATUS_OFF  = 12'h004;
  localparam logic [11:0] LEN_OFF     = 12'h008;
  localparam logic [11:0] WEIGHT_BASE = 12'h040;
  localparam logic [11:0] INPUT_BASE  = 12'h100;
  localparam logic [11:0] OUTPUT_BASE = 12'h200;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_RELU_BIT   = 2;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_ERR_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  // Enough headroom for K full-scale signed products without overflow.
  function automatic int acc_width(input int data_w, input int k);
    return 2 * data_w + $clog2(k);
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate with synchronous clear and an output stage that
// applies optional ReLU and sign-extends the accumulator to 32 bits.
module conv_mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     relu,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic [31:0]              result
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    result = (relu && acc_q[ACC_W-1]) ? 32'd0 : 32'(acc_q);
  end

endmodule

// File: rtl/wb_conv_engine.sv
// Wishbone-slave 1-D convolution engine: register/buffer decode, weight, input
// and output buffers, and the sequencing FSM that drives conv_mac_unit.
module wb_conv_engine
  import conv_acc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int DEPTH  = 16,
  parameter int ACC_W  = acc_width(DATA_W, K)
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  dbg_state_o
);

  localparam int WI_W = $clog2(K);
  localparam int DI_W = $clog2(DEPTH);
  localparam logic [9:0] W_WORD = WEIGHT_BASE[11:2];
  localparam logic [9:0] X_WORD = INPUT_BASE[11:2];
  localparam logic [9:0] O_WORD = OUTPUT_BASE[11:2];

  if (ACC_W > 32 || K < 2 || K > 8 || DEPTH < K || DEPTH > 64) begin : g_param_check
    $error("wb_conv_engine: illegal parameter combination");
  end

  logic                     ack_q, ack_d;
  logic [31:0]              dat_q, dat_d;
  logic                     irq_en_q, irq_en_d;
  logic                     relu_q, relu_d;
  logic                     relu_run_q, relu_run_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [6:0]               len_q, len_d;
  conv_state_e              state_q, state_d;
  logic [DI_W-1:0]          j_q, j_d;
  logic [WI_W-1:0]          t_q, t_d;
  logic signed [DATA_W-1:0] w_q [K];
  logic signed [DATA_W-1:0] w_d [K];
  logic signed [DATA_W-1:0] x_q [DEPTH];
  logic signed [DATA_W-1:0] x_d [DEPTH];
  logic [31:0]              out_q [DEPTH];
  logic [31:0]              out_d [DEPTH];

  logic            req, wr, busy, start_req;
  logic [9:0]      wi;
  logic            w_hit, x_hit, o_hit;
  logic [WI_W-1:0] w_idx;
  logic [DI_W-1:0] d_idx;
  logic [DI_W-1:0] xi;
  logic [6:0]      last_j;
  logic [31:0]     rd_data;
  logic            mac_clr, mac_en;
  logic [31:0]     mac_result;
  logic            unused_bits;

  assign unused_bits = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

  // Buffer bases are aligned to their sizes, so low address bits index directly.
  always_comb begin
    wi    = wbs_adr_i[11:2];
    req   = wbs_stb_i & wbs_cyc_i;
    wr    = req & wbs_we_i & ack_q;
    busy  = (state_q == ST_MAC) || (state_q == ST_STORE);
    w_hit = (wi >= W_WORD) && (wi < W_WORD + 10'(K));
    x_hit = (wi >= X_WORD) && (wi < X_WORD + 10'(DEPTH));
    o_hit = (wi >= O_WORD) && (wi < O_WORD + 10'(DEPTH));
    w_idx = wi[WI_W-1:0];
    d_idx = wi[DI_W-1:0];
    xi    = j_q + DI_W'(t_q);
    last_j = len_q - 7'(K);
  end

  always_comb begin
    rd_data = '0;
    if (wi == CTRL_OFF[11:2]) begin
      rd_data[CTRL_IRQ_EN_BIT] = irq_en_q;
      rd_data[CTRL_RELU_BIT]   = relu_q;
    end else if (wi == STATUS_OFF[11:2]) begin
      rd_data[STATUS_BUSY_BIT] = busy;
      rd_data[STATUS_DONE_BIT] = done_q;
      rd_data[STATUS_ERR_BIT]  = err_q;
    end else if (wi == LEN_OFF[11:2]) begin
      rd_data[6:0] = len_q;
    end else if (w_hit) begin
      rd_data = 32'(w_q[w_idx]);
    end else if (x_hit) begin
      rd_data = 32'(x_q[d_idx]);
    end else if (o_hit) begin
      rd_data = out_q[d_idx];
    end
  end

  // Bus writes land on the ack cycle; FSM updates follow so a DONE set beats a W1C.
  always_comb begin
    ack_d      = req & ~ack_q;
    dat_d      = ack_d ? rd_data : dat_q;
    irq_en_d   = irq_en_q;
    relu_d     = relu_q;
    relu_run_d = relu_run_q;
    done_d     = done_q;
    err_d      = err_q;
    len_d      = len_q;
    state_d    = state_q;
    j_d        = j_q;
    t_d        = t_q;
    w_d        = w_q;
    x_d        = x_q;
    out_d      = out_q;
    start_req  = 1'b0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;

    if (wr) begin
      if (wi == CTRL_OFF[11:2]) begin
        irq_en_d  = wbs_dat_i[CTRL_IRQ_EN_BIT];
        relu_d    = wbs_dat_i[CTRL_RELU_BIT];
        start_req = wbs_dat_i[CTRL_START_BIT];
      end else if (wi == STATUS_OFF[11:2]) begin
        if (wbs_dat_i[STATUS_DONE_BIT]) done_d = 1'b0;
        if (wbs_dat_i[STATUS_ERR_BIT])  err_d  = 1'b0;
      end else if (!busy) begin
        if (wi == LEN_OFF[11:2]) len_d = wbs_dat_i[6:0];
        else if (w_hit)          w_d[w_idx] = wbs_dat_i[DATA_W-1:0];
        else if (x_hit)          x_d[d_idx] = wbs_dat_i[DATA_W-1:0];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          if (len_q < 7'(K) || len_q > 7'(DEPTH)) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d      = 1'b0;
            done_d     = 1'b0;
            relu_run_d = relu_d;
            j_d        = '0;
            t_d        = '0;
            mac_clr    = 1'b1;
            state_d    = ST_MAC;
          end
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (t_q == WI_W'(K - 1)) state_d = ST_STORE;
        else                     t_d = t_q + 1'b1;
      end
      ST_STORE: begin
        out_d[j_q] = mac_result;
        if (7'(j_q) == last_j) begin
          state_d = ST_DONE;
        end else begin
          j_d     = j_q + 1'b1;
          t_d     = '0;
          mac_clr = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      irq_en_q   <= 1'b0;
      relu_q     <= 1'b0;
      relu_run_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= '0;
      state_q    <= ST_IDLE;
      j_q        <= '0;
      t_q        <= '0;
      for (int i = 0; i < K; i++)     w_q[i]   <= '0;
      for (int i = 0; i < DEPTH; i++) x_q[i]   <= '0;
      for (int i = 0; i < DEPTH; i++) out_q[i] <= '0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      irq_en_q   <= irq_en_d;
      relu_q     <= relu_d;
      relu_run_q <= relu_run_d;
      done_q     <= done_d;
      err_q      <= err_d;
      len_q      <= len_d;
      state_q    <= state_d;
      j_q        <= j_d;
      t_q        <= t_d;
      w_q        <= w_d;
      x_q        <= x_d;
      out_q      <= out_d;
    end
  end

  conv_mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clr   (mac_clr),
    .en    (mac_en),
    .relu  (relu_run_q),
    .a     (w_q[t_q]),
    .b     (x_q[xi]),
    .result(mac_result)
  );

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign irq_o       = done_q & irq_en_q;
  assign busy_o      = busy;
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/wb_conv_engine.md
# wb_conv_engine

Parametrised Wishbone-slave 1-D convolution engine, the successor to the fixed-function `top_wb_1` convolution core in the Caravel user project area. Firmware loads K signed weights and up to DEPTH signed input samples over Wishbone, then sets a start bit. A sequential MAC engine produces N-K+1 outputs into an output buffer, and the engine signals completion via status, a level IRQ and debug flags.

## Interface
Parameters:
- DATA_W, 8, sample/weight width (signed two's complement)
- K, 3, number of taps (2..8)
- DEPTH, 16, input-buffer depth in samples (K..64)
- ACC_W, 2*DATA_W+$clog2(K), accumulator width; must be ≤ 32 (elaboration check)

Ports:
- wb_clk_i  in  1  clock; the single clock for the block
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte select; ignored, all accesses are full-word
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  address; word index = wbs_adr_i[11:2]
- wbs_ack_o  out  1  registered acknowledge
- wbs_dat_o  out  32  read data
- irq_o  out  1  level interrupt
- busy_o  out  1  engine running (debug/LA)
- done_o  out  1  STATUS.done mirror (debug/IO)
- dbg_state_o  out  2  FSM state encoding (debug/LA)

## Operation
Register map (byte offsets):
- 0x000 CTRL: bit0 start (write-1 pulse, reads 0), bit1 irq_en, bit2 relu.
- 0x004 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 err (W1C).
- 0x008 LEN: N, number of valid input samples, 7 bits.
- 0x040 + 4i, i<K: weight i, low DATA_W bits.
- 0x100 + 4i, i<DEPTH: input i.
- 0x200 + 4j, j<DEPTH: output j (RO), 32-bit sign-extended result.
- Reads of unmapped addresses return 0; writes to them are acked and ignored.

Behaviour:
- Output j = sum over t<K of w[t]*x[j+t], computed in full ACC_W precision with no saturation, then sign-extended to 32 bits.
- With relu=1, negative results are stored as 0.
- A start with N<K or N>DEPTH sets err=1 and done=1 without entering MAC; the output buffer is unchanged.
- A start while busy is ignored. CTRL.irq_en/relu writes still take effect, but relu is sampled at start.
- Writes to weights, inputs or LEN while busy are acked and dropped.
- A valid start clears done and err.
- irq_o = done & irq_en.

FSM (dbg_state_o):
- IDLE=0 → MAC=1 on valid start; clear the accumulator and set j=0, t=0.
- MAC: accumulate one product per cycle; after t=K-1 go to STORE=2.
- STORE: write out[j] (ReLU applied). If j=N-K go to DONE=3, else j++, t=0, clear the accumulator and return to MAC.
- DONE: set done and return to IDLE in one cycle.
- busy_o is high in MAC and STORE.

## Timing
- Ack: wbs_ack_o rises the cycle after stb&cyc&!ack and stays high for exactly 1 cycle. There are no back-to-back acks, so a minimum of 2 cycles per access.
- Read data is valid with ack.
- Start is taken on the ack cycle of the CTRL write. The FSM enters MAC the next cycle.
- Run latency from the MAC entry cycle to done=1: (N-K+1)*(K+1)+1 cycles.
- Reset values: all registers, weights and buffers 0; FSM IDLE; wbs_ack_o=0, wbs_dat_o=0, irq_o=0, busy_o=0, done_o=0, dbg_state_o=0.
- Reset asserted mid-run aborts the run on the next edge and returns everything to reset values.
- A Wishbone W1C of done in the same cycle as FSM DONE: the set wins.

## Structure
- Package `conv_acc_pkg` holds:
  - register offsets
  - the FSM state enum (IDLE/MAC/STORE/DONE)
  - the CTRL/STATUS bit positions
  - an `acc_width(data_w,k)` function
- Sub-module `conv_mac_unit` holds:
  - the signed multiplier and ACC_W accumulator
  - clear/enable inputs
  - ReLU and 32-bit sign-extension output stage
- Wishbone decode, buffers and FSM live in the top module.

## Test plan
- Basic run (defaults): weights 1,2,1; inputs 1,2,3,4,5; N=5; start → out[0..2]=8,12,16. done=1 exactly 13 cycles after MAC entry; out[3]=0.
- Signed/ReLU: weights -1,0,0; inputs 5,5,5; N=3:
  - relu=0 → out[0]=0xFFFFFFFB
  - rerun with relu=1 → out[0]=0
- Error path: N=2 (<K), start → err=1, done=1, busy never high, outputs unchanged. A W1C of 0x6 clears both.
- IRQ and busy protection:
  - irq_en=1 run → irq_o high after done, low after W1C done.
  - A second start and a weight write during busy leave results identical to the first run.
- Reset mid-run: assert wb_rst_i during MAC for 1 cycle → next cycle state=IDLE, busy_o=0, all buffers read 0.
- Wishbone protocol: hold stb&cyc high for 4 cycles → ack pulses on cycles 2 and 4. A read of 0x3FC returns 0.
